// File: rtl/mem_copy_dma.sv
// Word-copy bus master: reads len_words words from src and writes each to dst over the PicoRV32 valid/ready port.
// One idle bus cycle follows every handshake; a stalled request aborts with err after TIMEOUT cycles.
module mem_copy_dma #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_GAP_R = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_GAP_W = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int              WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic [2:0]        state;
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       data_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    assign mem_instr = 1'b0;
    assign timed_out = (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is still high during the done cycle, which keeps start ignored there
                    busy <= 1'b0;
                    if (start && !busy) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len_words;
                        err        <= 1'b0;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                            err   <= 1'b1;
                            state <= S_FIN;
                        end else if (len_words == '0) begin
                            state <= S_FIN;
                        end else begin
                            state     <= S_RD;
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr;
                            mem_wstrb <= 4'b0000;
                            wait_cnt  <= '0;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        data_q    <= mem_rdata;
                        src_q     <= src_q + 32'd4;
                        mem_valid <= 1'b0;
                        state     <= S_GAP_R;
                    end else if (timed_out) begin
                        mem_valid <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_GAP_R: begin
                    state     <= S_WR;
                    mem_valid <= 1'b1;
                    mem_addr  <= dst_q;
                    mem_wdata <= data_q;
                    mem_wstrb <= 4'b1111;
                    wait_cnt  <= '0;
                end
                S_WR: begin
                    if (mem_ready) begin
                        dst_q      <= dst_q + 32'd4;
                        words_done <= words_done + LEN_W'(1);
                        mem_valid  <= 1'b0;
                        mem_wstrb  <= 4'b0000;
                        state      <= S_GAP_W;
                    end else if (timed_out) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        err       <= 1'b1;
                        state     <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_GAP_W: begin
                    if (words_done == len_q) begin
                        state <= S_FIN;
                    end else begin
                        state     <= S_RD;
                        mem_valid <= 1'b1;
                        mem_addr  <= src_q;
                        mem_wstrb <= 4'b0000;
                        wait_cnt  <= '0;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
